// File: rtl/ternary_threes_comp_decoder_pkg.sv
// Shared trit encodings, decoder FSM state codes and the elaboration-time power-of-three helper.
package ternary_pkg;

    localparam logic [1:0] TRIT_0   = 2'b00;
    localparam logic [1:0] TRIT_1   = 2'b01;
    localparam logic [1:0] TRIT_2   = 2'b10;
    localparam logic [1:0] TRIT_BAD = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_FIXUP = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic int unsigned pow3(input int n);
        int unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 3;
        return r;
    endfunction

endpackage

// File: rtl/ternary_threes_comp_decoder_if.sv
// Input word and output result handshakes of the 3's-complement decoder.
interface ternary_threes_comp_decoder_if #(
    parameter int N     = 4,
    parameter int OUT_W = 8
);
    logic             inValid;
    logic             inReady;
    logic [2*N-1:0]   inTrits;
    logic             outValid;
    logic             outReady;
    logic [OUT_W-1:0] outValue;
    logic             outError;

    modport master (
        output inValid, inTrits, outReady,
        input  inReady, outValid, outValue, outError
    );

    modport slave (
        input  inValid, inTrits, outReady,
        output inReady, outValid, outValue, outError
    );
endinterface

// File: rtl/ternary_trit_mac.sv
// One Horner step: acc*3 + trit, with illegal trit codes contributing zero.
module ternary_trit_mac
    import ternary_pkg::*;
#(
    parameter int ACC_W = 7
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [1:0]       trit,
    output logic [ACC_W-1:0] sum,
    output logic             bad
);
    logic [1:0] digit;

    always_comb begin
        bad   = (trit == TRIT_BAD);
        digit = bad ? TRIT_0 : trit;
        sum   = (acc << 1) + acc + ACC_W'(digit);
    end
endmodule

// File: rtl/ternary_threes_comp_decoder.sv
// Serial MSB-first decoder from an N-trit 3's-complement word to signed two's-complement binary.
module ternary_threes_comp_decoder
    import ternary_pkg::*;
#(
    parameter int N     = 4,
    parameter int OUT_W = 8
) (
    input logic clk,
    input logic rst_n,
    ternary_threes_comp_decoder_if.slave bus
);
    localparam int unsigned P3    = pow3(N);
    localparam int unsigned HALF  = (P3 - 1) / 2;
    localparam int          ACC_W = $clog2(P3);
    localparam int          CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [ACC_W-1:0] HALF_A = ACC_W'(HALF);
    localparam logic [OUT_W-1:0] P3_O   = OUT_W'(P3);

    generate
        if (OUT_W < ACC_W + 1) begin : g_width_check
            $error("OUT_W is too narrow to hold a signed %0d-trit value", N);
        end
    endgenerate

    logic [1:0]          state, state_next;
    logic [N-1:0][1:0]   word;
    logic [CNT_W-1:0]    cnt;
    logic [ACC_W-1:0]    acc;
    logic                err;
    logic                ready;
    logic [OUT_W-1:0]    value;
    logic                error_q;
    logic [ACC_W-1:0]    mac_sum;
    logic                mac_bad;
    logic [OUT_W-1:0]    v_ext;
    logic [OUT_W-1:0]    fix_val;
    logic                accept;

    ternary_trit_mac #(.ACC_W(ACC_W)) u_mac (
        .acc  (acc),
        .trit (word[cnt]),
        .sum  (mac_sum),
        .bad  (mac_bad)
    );

    assign accept = bus.inValid && ready;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept) state_next = ST_ACCUM;
            ST_ACCUM: if (cnt == '0) state_next = ST_FIXUP;
            ST_FIXUP: state_next = ST_DONE;
            ST_DONE:  if (bus.outReady) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Upper half of the unsigned range wraps to negatives: V > H maps to V - 3^N.
    always_comb begin
        v_ext   = {{(OUT_W-ACC_W){1'b0}}, acc};
        fix_val = (acc > HALF_A) ? (v_ext - P3_O) : v_ext;
        if (err) fix_val = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            word    <= '0;
            cnt     <= '0;
            acc     <= '0;
            err     <= 1'b0;
            ready   <= 1'b0;
            value   <= '0;
            error_q <= 1'b0;
        end else begin
            state <= state_next;
            // Registered so ready stays low through reset and only re-arms a cycle after a pop.
            ready <= (state_next == ST_IDLE);
            case (state)
                ST_IDLE: if (accept) begin
                    word <= bus.inTrits;
                    acc  <= '0;
                    err  <= 1'b0;
                    cnt  <= CNT_W'(N - 1);
                end
                ST_ACCUM: begin
                    acc <= mac_sum;
                    err <= err | mac_bad;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                ST_FIXUP: begin
                    value   <= fix_val;
                    error_q <= err;
                end
                default: ;
            endcase
        end
    end

    assign bus.inReady  = ready;
    assign bus.outValid = (state == ST_DONE);
    assign bus.outValue = value;
    assign bus.outError = error_q;

endmodule
